// File: rtl/lfsr_prng_stream_if.sv
// Stream/control bundle for lfsr_prng_stream; master = generator, slave = controller/consumer.
// LFSR_PERIOD_CNT_EN adds the step_cnt/period/period_valid observation signals.
interface lfsr_prng_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load_seed;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] rand_num;
  logic             rand_valid;
  logic             rand_ready;
  logic             wrap;
  logic             zero_seed_err;
`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] period;
  logic             period_valid;

  modport master (
    input  en, load_seed, seed, rand_ready,
    output rand_num, rand_valid, wrap, zero_seed_err, step_cnt, period, period_valid
  );
  modport slave (
    output en, load_seed, seed, rand_ready,
    input  rand_num, rand_valid, wrap, zero_seed_err, step_cnt, period, period_valid
  );
`else
  modport master (
    input  en, load_seed, seed, rand_ready,
    output rand_num, rand_valid, wrap, zero_seed_err
  );
  modport slave (
    output en, load_seed, seed, rand_ready,
    input  rand_num, rand_valid, wrap, zero_seed_err
  );
`endif
endinterface

// File: rtl/lfsr_prng_stream.sv
// Parametrised Fibonacci/Galois LFSR with a valid/ready output stream and wrap detection.
// Define LFSR_PERIOD_CNT_EN to add the transfer counter and measured-period outputs.
module lfsr_prng_stream #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 'hB8,
  parameter int unsigned      MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_SEED = 'd1
) (
  input logic                clk,
  input logic                rst,
  lfsr_prng_stream_if.master s
);
  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_prng_stream: WIDTH %0d outside 3..32", WIDTH);
  end else if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $error("lfsr_prng_stream: TAPS MSB must be 1");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_prng_stream: RESET_SEED must be nonzero");
  end
  if (MODE > 1) begin : g_bad_mode
    $error("lfsr_prng_stream: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  logic             r_valid;
  logic             r_wrap;
  logic             r_zse;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_xfer;
  logic             w_hit_seed;

  if (MODE == 0) begin : g_fib
    logic w_fb;
    always_comb begin
      w_fb   = ^(r_state & TAPS);
      w_next = {r_state[WIDTH-2:0], w_fb};
    end
  end else begin : g_gal
    always_comb begin
      w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    end
  end

  always_comb begin
    w_xfer     = r_valid & s.rand_ready & s.en & ~s.load_seed;
    w_load_val = (s.seed == '0) ? One : s.seed;
    w_hit_seed = (w_next == r_seed);
  end

  // Load has priority over a same-cycle transfer; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RESET_SEED;
      r_seed  <= RESET_SEED;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_zse   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_zse  <= 1'b0;
      if (s.load_seed) begin
        r_state <= w_load_val;
        r_seed  <= w_load_val;
        r_valid <= 1'b1;
        r_zse   <= (s.seed == '0);
      end else if (w_xfer) begin
        r_state <= w_next;
        r_wrap  <= w_hit_seed;
      end
    end
  end

  always_comb begin
    s.rand_num      = r_state;
    s.rand_valid    = r_valid;
    s.wrap          = r_wrap;
    s.zero_seed_err = r_zse;
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_period_valid;

  always_ff @(posedge clk) begin
    if (!rst || s.load_seed) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else if (w_xfer) begin
      if (w_hit_seed) begin
        r_cnt <= '0;
        if (!r_period_valid) begin
          r_period       <= r_cnt + One;
          r_period_valid <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + One;
      end
    end
  end

  always_comb begin
    s.step_cnt     = r_cnt;
    s.period       = r_period;
    s.period_valid = r_period_valid;
  end
`endif
endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Randomised + directed bench for lfsr_prng_stream: Fibonacci and Galois instances run in lockstep
// against an arithmetic reference model.
module tb_lfsr_prng_stream;
  localparam logic [7:0] Taps = 8'hB8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lfsr_prng_stream_if #(.WIDTH(8)) u_if0 ();
  lfsr_prng_stream_if #(.WIDTH(8)) u_if1 ();

  lfsr_prng_stream #(.WIDTH(8), .TAPS(Taps), .MODE(0), .RESET_SEED(8'h01)) u_dut_fib (
    .clk (clk),
    .rst (rst),
    .s   (u_if0)
  );
  lfsr_prng_stream #(.WIDTH(8), .TAPS(Taps), .MODE(1), .RESET_SEED(8'h01)) u_dut_gal (
    .clk (clk),
    .rst (rst),
    .s   (u_if1)
  );

  // Reference model state, index 0 = Fibonacci, 1 = Galois.
  logic [7:0] m_state  [2];
  logic [7:0] m_seed   [2];
  logic [7:0] m_cnt    [2];
  logic [7:0] m_period [2];
  logic       m_valid  [2];
  logic       m_wrap   [2];
  logic       m_zse    [2];
  logic       m_pv     [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next value from the textbook rules: shift-as-multiply plus tap parity, or halve-and-xor.
  function automatic logic [7:0] ref_next(input int mode, input logic [7:0] st);
    int v;
    v = int'(st);
    if (mode == 0) return 8'(((v * 2) % 256) + ($countones(st & Taps) % 2));
    return 8'(v / 2) ^ (((v % 2) == 1) ? Taps : 8'h00);
  endfunction

  task automatic model_clock(input logic r, input logic e, input logic l, input logic [7:0] sd,
                             input logic rd);
    logic [7:0] nx;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      m_zse[k]  = 1'b0;
      if (!r) begin
        m_state[k] = 8'h01; m_seed[k] = 8'h01; m_valid[k] = 1'b0;
        m_cnt[k] = 8'h00; m_period[k] = 8'h00; m_pv[k] = 1'b0;
      end else if (l) begin
        m_state[k] = (sd == 8'h00) ? 8'h01 : sd;
        m_seed[k]  = m_state[k];
        m_valid[k] = 1'b1;
        m_zse[k]   = (sd == 8'h00);
        m_cnt[k] = 8'h00; m_period[k] = 8'h00; m_pv[k] = 1'b0;
      end else if (m_valid[k] && rd && e) begin
        nx = ref_next(k, m_state[k]);
        m_wrap[k]  = (nx == m_seed[k]);
        m_state[k] = nx;
        if (m_wrap[k]) begin
          if (!m_pv[k]) begin
            m_period[k] = m_cnt[k] + 8'd1;
            m_pv[k]     = 1'b1;
          end
          m_cnt[k] = 8'h00;
        end else begin
          m_cnt[k] = m_cnt[k] + 8'd1;
        end
      end
    end
  endtask

  task automatic compare_dut(input int k, input logic [7:0] num, input logic v, input logic w,
                             input logic z, input logic [7:0] cnt, input logic [7:0] per,
                             input logic pv);
    check($sformatf("d%0d_num", k), {24'h0, num}, {24'h0, m_state[k]});
    check($sformatf("d%0d_valid", k), {31'h0, v}, {31'h0, m_valid[k]});
    check($sformatf("d%0d_wrap", k), {31'h0, w}, {31'h0, m_wrap[k]});
    check($sformatf("d%0d_zse", k), {31'h0, z}, {31'h0, m_zse[k]});
`ifdef LFSR_PERIOD_CNT_EN
    check($sformatf("d%0d_cnt", k), {24'h0, cnt}, {24'h0, m_cnt[k]});
    check($sformatf("d%0d_period", k), {24'h0, per}, {24'h0, m_period[k]});
    check($sformatf("d%0d_pvalid", k), {31'h0, pv}, {31'h0, m_pv[k]});
`endif
  endtask

  task automatic compare_all();
`ifdef LFSR_PERIOD_CNT_EN
    compare_dut(0, u_if0.rand_num, u_if0.rand_valid, u_if0.wrap, u_if0.zero_seed_err,
                u_if0.step_cnt, u_if0.period, u_if0.period_valid);
    compare_dut(1, u_if1.rand_num, u_if1.rand_valid, u_if1.wrap, u_if1.zero_seed_err,
                u_if1.step_cnt, u_if1.period, u_if1.period_valid);
`else
    compare_dut(0, u_if0.rand_num, u_if0.rand_valid, u_if0.wrap, u_if0.zero_seed_err,
                8'h00, 8'h00, 1'b0);
    compare_dut(1, u_if1.rand_num, u_if1.rand_valid, u_if1.wrap, u_if1.zero_seed_err,
                8'h00, 8'h00, 1'b0);
`endif
  endtask

  // Called at a negedge: drive, clock once, update the model, compare at the next negedge.
  task automatic cycle(input logic r, input logic e, input logic l, input logic [7:0] sd,
                       input logic rd);
    rst = r;
    u_if0.en = e; u_if0.load_seed = l; u_if0.seed = sd; u_if0.rand_ready = rd;
    u_if1.en = e; u_if1.load_seed = l; u_if1.seed = sd; u_if1.rand_ready = rd;
    @(posedge clk);
    model_clock(r, e, l, sd, rd);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [7:0] held;
    logic       seen [256];
    int         distinct, nonzero, wraps, wrap_at;
    logic       r, e, l, rd;
    logic [7:0] sd;

    rst = 1'b0;
    u_if0.en = 1'b0; u_if0.load_seed = 1'b0; u_if0.seed = 8'h00; u_if0.rand_ready = 1'b0;
    u_if1.en = 1'b0; u_if1.load_seed = 1'b0; u_if1.seed = 8'h00; u_if1.rand_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 8'h01; m_seed[k] = 8'h01; m_valid[k] = 1'b0; m_wrap[k] = 1'b0;
      m_zse[k] = 1'b0; m_cnt[k] = 8'h00; m_period[k] = 8'h00; m_pv[k] = 1'b0;
    end
    @(negedge clk);

    // Reset, with other inputs active to show reset dominates.
    cycle(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check("rst_num", {24'h0, u_if0.rand_num}, 32'h01);
    check("rst_valid", {31'h0, u_if0.rand_valid}, 32'h0);
    check("rst_wrap", {31'h0, u_if0.wrap}, 32'h0);
    check("rst_zse", {31'h0, u_if0.zero_seed_err}, 32'h0);
    // Valid must not rise from reset alone.
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    check("no_valid_wo_load", {31'h0, u_if0.rand_valid}, 32'h0);

    // Known sequences from seed 6A.
    cycle(1'b1, 1'b1, 1'b1, 8'h6A, 1'b1);
    check("fib_0", {24'h0, u_if0.rand_num}, 32'h6A);
    check("gal_0", {24'h0, u_if1.rand_num}, 32'h6A);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    check("fib_1", {24'h0, u_if0.rand_num}, 32'hD4);
    check("gal_1", {24'h0, u_if1.rand_num}, 32'h35);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    check("fib_2", {24'h0, u_if0.rand_num}, 32'hA8);
    check("gal_2", {24'h0, u_if1.rand_num}, 32'hA2);

    // Full period from 6A.
    cycle(1'b1, 1'b1, 1'b1, 8'h6A, 1'b1);
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0; nonzero = 0; wraps = 0; wrap_at = 0;
    for (int i = 1; i <= 255; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
      if (!seen[u_if0.rand_num]) distinct++;
      seen[u_if0.rand_num] = 1'b1;
      if (u_if0.rand_num != 8'h00) nonzero++;
      if (u_if0.wrap) begin
        wraps++;
        wrap_at = i;
      end
    end
    check("period_distinct", distinct, 255);
    check("period_nonzero", nonzero, 255);
    check("period_wraps", wraps, 1);
    check("period_wrap_at", wrap_at, 255);
    check("period_back_to_seed", {24'h0, u_if0.rand_num}, 32'h6A);
`ifdef LFSR_PERIOD_CNT_EN
    check("period_val", {24'h0, u_if0.period}, 32'd255);
    check("period_valid", {31'h0, u_if0.period_valid}, 32'h1);
`endif

    // Backpressure hold.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    held = m_state[0];
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      check("hold_num", {24'h0, u_if0.rand_num}, {24'h0, held});
    end

    // Zero seed replaced by 1, single error pulse.
    cycle(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    check("zero_seed_num", {24'h0, u_if0.rand_num}, 32'h01);
    check("zero_seed_err", {31'h0, u_if0.zero_seed_err}, 32'h1);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check("zero_seed_pulse", {31'h0, u_if0.zero_seed_err}, 32'h0);

    // Load beats a same-cycle transfer.
    cycle(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1);
    check("load_wins", {24'h0, u_if0.rand_num}, 32'h3C);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check("midrun_rst_num", {24'h0, u_if0.rand_num}, 32'h01);
    check("midrun_rst_valid", {31'h0, u_if0.rand_valid}, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      l  = ($urandom_range(0, 19) == 0);
      sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      e  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      cycle(r, e, l, sd, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
